// File: rtl/program_memory_spi_pkg.sv
// Shared definitions for the SPI-flash program memory: FSM encodings,
// flash opcode, and the bit counts of each transfer phase.
package program_memory_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_READ = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [7:0] READ_OPCODE = 8'h03;
   localparam int         CMD_BITS    = 8;
   localparam int         ADDR_BITS   = 24;
   localparam int         DATA_BITS   = 16;
   localparam int         CNT_W       = 5;

   // Flash is byte addressed, the CPU fetches 16-bit words.
   function automatic logic [23:0] byte_addr(input logic [15:0] word_addr);
      return {7'b0, word_addr, 1'b0};
   endfunction

   function automatic logic is_xfer(input state_t s);
      return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_READ);
   endfunction

endpackage

// File: rtl/program_memory_spi_bit_engine.sv
// SPI mode-0 bit engine: clk/2 serial clock, MSB-first MOSI shifter and
// MISO capture register.
module spi_bit_engine
   import program_memory_spi_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [23:0] load_word,
   input  logic        miso,
   output logic        sclk,
   output logic        mosi,
   output logic        rise,
   output logic        fall,
   output logic [15:0] rx_word
);

   logic [23:0] tx_sh;
   logic [15:0] rx_sh;

   // rise/fall flag the clk edge on which sclk will go high/low.
   assign rise    = en & ~sclk;
   assign fall    = en & sclk;
   assign mosi    = tx_sh[23];
   assign rx_word = rx_sh;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk  <= 1'b0;
         tx_sh <= '0;
      end else begin
         sclk <= en ? ~sclk : 1'b0;
         if (load)
            tx_sh <= load_word;
         else if (fall)
            tx_sh <= {tx_sh[22:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (rise)
         rx_sh <= {rx_sh[14:0], miso};
   end

endmodule

// File: rtl/program_memory_spi.sv
// Instruction fetch from an external SPI NOR flash (single-SPI 0x03 read),
// with a one-word cache of the last fetched address.
module program_memory_spi
   import program_memory_spi_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] address,
   output logic [15:0] instruction,
   output logic        ready,
   output logic        spi_cs,
   output logic        spi_sclk,
   output logic        spi_io0_o,
   output logic        spi_io0_oe,
   input  logic        spi_io0_i,
   output logic        spi_io1_o,
   output logic        spi_io1_oe,
   input  logic        spi_io1_i
);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
   logic [15:0]        fetch_addr;
   logic               addr_vld;
   logic               cs_q;
   logic               eng_en, eng_load, eng_rise, eng_fall;
   logic [23:0]        eng_word;
   logic [15:0]        rx_word;
   logic               latch_addr, done_load;
   logic               unused_io0;

   assign unused_io0 = spi_io0_i;
   assign eng_en     = is_xfer(state);

   spi_bit_engine u_engine (
      .clk       (clk),
      .rst       (rst),
      .en        (eng_en),
      .load      (eng_load),
      .load_word (eng_word),
      .miso      (spi_io1_i),
      .sclk      (spi_sclk),
      .mosi      (spi_io0_o),
      .rise      (eng_rise),
      .fall      (eng_fall),
      .rx_word   (rx_word)
   );

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      eng_load    = 1'b0;
      eng_word    = byte_addr(fetch_addr);
      latch_addr  = 1'b0;
      done_load   = 1'b0;
      case (state)
         ST_IDLE: begin
            state_nxt   = ST_CMD;
            bit_cnt_nxt = '0;
            eng_load    = 1'b1;
            eng_word    = {READ_OPCODE, 16'h0000};
            latch_addr  = 1'b1;
         end
         ST_CMD: begin
            if (eng_fall) begin
               if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                  state_nxt   = ST_ADDR;
                  bit_cnt_nxt = '0;
                  eng_load    = 1'b1;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         end
         ST_ADDR: begin
            if (eng_fall) begin
               if (bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
                  state_nxt   = ST_READ;
                  bit_cnt_nxt = '0;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         end
         ST_READ: begin
            // The fall after the 16th sample closes the transfer.
            if (eng_fall) begin
               if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                  state_nxt   = ST_DONE;
                  bit_cnt_nxt = '0;
                  done_load   = 1'b1;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (!(addr_vld && (address == fetch_addr)))
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         cs_q        <= 1'b1;
         ready       <= 1'b0;
         instruction <= 16'h0000;
         addr_vld    <= 1'b0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         cs_q     <= ~is_xfer(state_nxt);
         ready    <= (state_nxt == ST_DONE) && (address == fetch_addr) &&
                     (addr_vld || done_load);
         addr_vld <= done_load | (addr_vld & (state_nxt == ST_DONE));
         if (done_load)
            instruction <= rx_word;
      end
   end

   // Word address is frozen for the whole transfer; also the cache tag.
   always_ff @(posedge clk) begin
      if (latch_addr)
         fetch_addr <= address;
   end

   assign spi_cs     = cs_q;
   assign spi_io0_oe = ~cs_q;
   assign spi_io1_o  = 1'b0;
   assign spi_io1_oe = 1'b0;

endmodule

// File: tb/tb_program_memory_spi.sv
// Directed bench for program_memory_spi with a behavioural SPI flash model.
module tb_program_memory_spi;
   import program_memory_spi_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] address = 16'h1234;
   logic [15:0] instruction;
   logic        ready, spi_cs, spi_sclk;
   logic        spi_io0_o, spi_io0_oe, spi_io1_o, spi_io1_oe;
   logic        spi_io0_i = 1'b0;
   logic        spi_io1_i = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   program_memory_spi dut (
      .clk         (clk),
      .rst         (rst),
      .address     (address),
      .instruction (instruction),
      .ready       (ready),
      .spi_cs      (spi_cs),
      .spi_sclk    (spi_sclk),
      .spi_io0_o   (spi_io0_o),
      .spi_io0_oe  (spi_io0_oe),
      .spi_io0_i   (spi_io0_i),
      .spi_io1_o   (spi_io1_o),
      .spi_io1_oe  (spi_io1_oe),
      .spi_io1_i   (spi_io1_i)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] flash_word(input logic [15:0] a);
      case (a)
         16'h1234: return 16'hABCD;
         16'h1235: return 16'h5566;
         16'h9000: return 16'hDEAD;
         default:  return 16'h0000;
      endcase
   endfunction

   // Flash model and pin monitor, evaluated mid-cycle.
   logic        prev_cs = 1'b1, prev_sclk = 1'b0;
   logic [31:0] sh = '0, last_hdr = '0;
   logic [15:0] fw;
   int          pulses = 0, last_pulses = 0;
   logic        inv_bad = 1'b0;

   always @(negedge clk) begin
      if ((ready & ~spi_cs) | (spi_io0_oe ^ ~spi_cs) | spi_io1_oe | spi_io1_o)
         inv_bad = 1'b1;
      if (prev_cs && !spi_cs) begin
         pulses = 0;
         sh     = '0;
      end
      if (!spi_cs && spi_sclk && !prev_sclk) begin
         if (pulses < 32) sh = {sh[30:0], spi_io0_o};
         pulses++;
      end
      if (!prev_cs && spi_cs) begin
         last_hdr    = sh;
         last_pulses = pulses;
      end
      if (prev_sclk && !spi_sclk && dut.state == ST_READ) begin
         fw        = flash_word(sh[16:1]);
         spi_io1_i = fw[4'd15 - dut.bit_cnt[3:0]];
      end
      prev_cs   = spi_cs;
      prev_sclk = spi_sclk;
   end

   task automatic wait_ready(input int max_clk, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max_clk; i++) begin
         @(negedge clk);
         if (ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
   endtask

   task automatic wait_state(input state_t s, input int max_clk, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max_clk; i++) begin
         @(negedge clk);
         if (dut.state == s) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_cs_high(input int max_clk, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max_clk; i++) begin
         @(negedge clk);
         if (spi_cs === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      logic ok;
      repeat (3) @(negedge clk);
      check_eq("rst_cs",    spi_cs, 1);
      check_eq("rst_sclk",  spi_sclk, 0);
      check_eq("rst_ready", ready, 0);
      check_eq("rst_instr", instruction, 16'h0000);
      check_eq("rst_oe",    spi_io0_oe, 0);
      check_eq("rst_mosi",  spi_io0_o, 0);

      rst = 1'b1;
      wait_ready(100, ok);
      check_eq("lat_1234",    ok, 1);
      check_eq("instr_1234",  instruction, 16'hABCD);
      check_eq("hdr_1234",    last_hdr, 32'h0300_2468);
      check_eq("pulses_1234", last_pulses, 48);

      address = 16'h1235;
      @(negedge clk);
      check_eq("drop_1235",   ready, 0);
      wait_ready(110, ok);
      check_eq("lat_1235",    ok, 1);
      check_eq("instr_1235",  instruction, 16'h5566);
      check_eq("hdr_1235",    last_hdr, 32'h0300_246A);

      address = 16'h0042;
      wait_ready(110, ok);
      check_eq("lat_0042",    ok, 1);
      check_eq("instr_0042",  instruction, 16'h0000);

      // Address change while data bits are streaming in.
      address = 16'h1234;
      wait_state(ST_READ, 110, ok);
      check_eq("reach_read",  ok, 1);
      address = 16'h9000;
      wait_cs_high(60, ok);
      check_eq("first_done",  ok, 1);
      check_eq("stale_instr", instruction, 16'hABCD);
      check_eq("stale_ready", ready, 0);
      wait_ready(120, ok);
      check_eq("lat_9000",    ok, 1);
      check_eq("instr_9000",  instruction, 16'hDEAD);
      check_eq("hdr_9000",    last_hdr, 32'h0301_2000);
      check_eq("pulses_9000", last_pulses, 48);

      // Asynchronous reset while the address is being shifted.
      address = 16'h1235;
      wait_state(ST_ADDR, 110, ok);
      check_eq("reach_addr",  ok, 1);
      #2 rst = 1'b0;
      #1;
      check_eq("mid_cs",      spi_cs, 1);
      check_eq("mid_ready",   ready, 0);
      check_eq("mid_instr",   instruction, 16'h0000);
      check_eq("mid_sclk",    spi_sclk, 0);
      check_eq("mid_oe",      spi_io0_oe, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wait_ready(100, ok);
      check_eq("lat_post_rst",   ok, 1);
      check_eq("instr_post_rst", instruction, 16'h5566);

      check_eq("pin_invariants", inv_bad, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/program_memory_spi.md
PROGRAM_MEMORY_SPI -- requirements
Module: program_memory_spi

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset, with ports as follows.
- clk: input, 1 bit, system clock; all logic on rising edge.
- rst: input, 1 bit, asynchronous active-low reset.
- address: input, 16 bits, program word address requested by the CPU.
- instruction: output, 16 bits, fetched word; valid while ready=1.
- ready: output, 1 bit; high means instruction holds the data at the current address.
- spi_cs: output, 1 bit, flash chip select, active-low.
- spi_sclk: output, 1 bit, SPI clock, mode 0, idle low.
- spi_io0_o / spi_io0_oe / spi_io0_i: output / output / input, 1 bit each; IO0 is MOSI.
- spi_io1_o / spi_io1_oe / spi_io1_i: output / output / input, 1 bit each; IO1 is MISO.

Function
REQ-002 SHALL use a 3-bit state register: IDLE=0, CMD=1, ADDR=2, READ=3, DONE=4.
REQ-003 SHALL generate spi_sclk as clk/2: one clk cycle high, one clk cycle low per bit.
REQ-004 SHALL shift MOSI out MSB-first, changing only while sclk is low; the flash samples on sclk rising edges.
REQ-005 SHALL sample MISO (spi_io1_i) into the shift register on the clk where sclk rises.
REQ-006 SHALL use single-SPI read:
- command 0x03 (8 bits);
- then 24-bit byte address {7'b0, address, 1'b0}, i.e. byte address = 2×word address;
- then 16 data bits, MSB first.
REQ-007 SHALL drive spi_io0_oe=1 while spi_cs=0 and 0 otherwise; spi_io1_oe and spi_io1_o SHALL be constant 0.
REQ-008 IDLE→CMD: spi_cs drops and the first command bit is driven while sclk is still low; spi_cs drops at least one clk before the first sclk rise.
REQ-009 CMD→ADDR after 8 bits; ADDR→READ after 24 bits.
REQ-010 The state change to READ, with bit_cnt=0, SHALL occur on the same clk as the sclk falling edge that ends the last address bit.
REQ-011 In READ, a 4-bit bit_cnt SHALL equal i during data bit i (0..15); it increments on the same clk as the sclk falling edge that ends bit i.
REQ-012 After the 16th data-bit sample:
- spi_sclk returns low and spi_cs goes high;
- instruction is loaded with the shifted word;
- the fetched address is latched;
- the state goes to DONE.
REQ-013 In DONE, ready SHALL be 1 while address equals the latched address.
REQ-014 When address differs from the latched address, ready SHALL drop on the next clk and a new fetch SHALL start (DONE→IDLE→CMD).
REQ-015 An address change mid-fetch SHALL NOT abort the transfer; the mismatch is detected in DONE and triggers a refetch, and ready stays 0 until it completes.
REQ-016 Fetch latency from leaving IDLE to ready=1 SHALL be ≤100 clk cycles (48 sclk bits).
REQ-017 ready SHALL never be 1 while spi_cs=0.

Reset
REQ-018 rst=0 SHALL immediately force:
- state=IDLE and bit_cnt=0;
- instruction=0x0000 and ready=0;
- spi_cs=1 and spi_sclk=0;
- spi_io0_o=0 and spi_io0_oe=0;
- the latched-address valid flag cleared.
REQ-019 After rst rises, the first fetch of the current address SHALL start on the next clk.
REQ-020 Reset mid-transfer SHALL abort the transfer cleanly: spi_cs high and no partial instruction update.

Structure
REQ-021 A shared package SHALL hold:
- the state encodings;
- the READ opcode 0x03;
- the bit counts 8/24/16.
REQ-022 One sub-module, spi_bit_engine, is permitted for sclk generation and shifting. The FSM and address compare stay in program_memory_spi.

Verification
REQ-023 The bench SHALL model a flash that drives MISO on sclk falling edges while state=READ, bit = data[15-bit_cnt], with:
- 0x1234→0xABCD;
- 0x1235→0x5566;
- 0x9000→0xDEAD;
- all other addresses→0x0000.
REQ-024 address=0x1234, release reset → ready=1 and instruction=0xABCD within 100 clks.
REQ-025 Then set address=0x1235 → ready drops to 0, then rises with instruction=0x5566.
REQ-026 Decode MOSI during the 0x1234 fetch → bytes 0x03, 0x00, 0x24, 0x68; spi_cs low for exactly 48 sclk pulses.
REQ-027 Change address from 0x1234 to 0x9000 mid-READ → the first transfer completes, a refetch follows, and the final result is ready=1 with instruction=0xDEAD.
REQ-028 Assert rst during ADDR → spi_cs=1, ready=0, instruction=0x0000 immediately; after release the correct word is fetched.
